// File: rtl/rv_ctrl_pkg.sv
// Shared control encodings for the multicycle RV32 sequencer: FSM states,
// major opcodes, ALU/writeback/PC select codes and an opcode classifier.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  // Writeback mux order must match the datapath: ALU, load data, pc+4, pc+imm.
  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_LOAD  = 2'b01;
  localparam logic [1:0] WB_PC4   = 2'b10;
  localparam logic [1:0] WB_PCIMM = 2'b11;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  typedef enum logic [3:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_LUI,
    CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_SYSTEM, CLS_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify(input logic [6:0] opc);
    case (opc)
      OPC_R:      return CLS_R;
      OPC_I:      return CLS_I;
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_LUI:    return CLS_LUI;
      OPC_AUIPC:  return CLS_AUIPC;
      OPC_JAL:    return CLS_JAL;
      OPC_JALR:   return CLS_JALR;
      OPC_SYSTEM: return CLS_SYSTEM;
      default:    return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory-wait watchdog: counts stalled request cycles and flags the cycle on
// which the count would reach WAIT_LIMIT (WAIT_LIMIT = 0 disables it).
module wait_timer #(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire_c = (WAIT_LIMIT != 32'd0) && en_i &&
                    (cnt_q == CNT_W'(WAIT_LIMIT - 32'd1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_c) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle RV32 control sequencer: fetch/decode/exec/mem/wb FSM with a
// memory-wait watchdog and a retired-instruction counter.
module mc_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter int unsigned CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  wb_sel,
  output logic [1:0]  pc_sel,
  output logic [2:0]  state,
  output logic        halted,
  output logic        error,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  op_class_e   cls;
  logic        in_fetch, in_mem, wait_en, wait_clr, timeout;

  assign cls      = classify(opcode);
  assign in_fetch = (state_q == ST_FETCH);
  assign in_mem   = (state_q == ST_MEM);

  // Timer is driven from the registered state so ready outside a request is ignored.
  assign wait_en  = (in_fetch && !imem_ready) || (in_mem && !dmem_ready);
  assign wait_clr = !(in_fetch || in_mem) || (in_fetch && imem_ready) ||
                    (in_mem && dmem_ready);

  wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (CNT_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .en_i     (wait_en),
    .clr_i    (wait_clr),
    .expire_c (timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    reg_we    = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    alu_op    = ALU_OP_ADD;
    wb_sel    = WB_ALU;
    pc_sel    = PC_PLUS4;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_DECODE: begin
        case (cls)
          CLS_SYSTEM:  state_d = ST_HALT;
          CLS_ILLEGAL: state_d = ST_ERR;
          default:     state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        alu_src_a = (cls == CLS_LUI);
        alu_src_b = !((cls == CLS_R) || (cls == CLS_BRANCH));
        if ((cls == CLS_R) || (cls == CLS_I)) alu_op = ALU_OP_FUNCT;
        else if (cls == CLS_BRANCH)           alu_op = ALU_OP_BRANCH;
        case (cls)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = zero ? PC_IMM : PC_PLUS4;
            state_d = ST_FETCH;
          end
          default: state_d = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls == CLS_STORE);
        if (dmem_ready) begin
          if (cls == CLS_STORE) begin
            pc_we   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (timeout) begin
          state_d = ST_ERR;
        end
      end
      ST_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = ST_FETCH;
        case (cls)
          CLS_LOAD:          wb_sel = WB_LOAD;
          CLS_JAL, CLS_JALR: wb_sel = WB_PC4;
          CLS_AUIPC:         wb_sel = WB_PCIMM;
          default:           wb_sel = WB_ALU;
        endcase
        if (cls == CLS_JAL)       pc_sel = PC_IMM;
        else if (cls == CLS_JALR) pc_sel = PC_ALU;
      end
      ST_HALT: state_d = ST_HALT;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_ERR;
    endcase

    // One pc_we per retired instruction, so it doubles as the retire strobe.
    instret_d = instret_q + 32'(pc_we);
  end

  assign state   = state_q;
  assign halted  = (state_q == ST_HALT);
  assign error   = (state_q == ST_ERR);
  assign instret = instret_q;

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 Parameter: WAIT_LIMIT, 16, memory-wait cycles before error (0 = timeout disabled).
REQ-002 Parameter: CNT_W, 8, width of wait counter (must hold WAIT_LIMIT).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  begin execution from IDLE.
REQ-006 opcode  in  7  instr[6:0] from instruction register.
REQ-007 zero  in  1  ALU branch-condition-met flag.
REQ-008 imem_ready  in  1  instruction memory data valid this cycle.
REQ-009 dmem_ready  in  1  data memory access complete this cycle.
REQ-010 imem_req  out  1  instruction fetch request.
REQ-011 dmem_req  out  1  data access request; dmem_we  out  1  write qualifier.
REQ-012 ir_we, pc_we, reg_we  out  1 each  instruction register, PC, register file write enables.
REQ-013 alu_src_a  out  1  0 = rs1, 1 = zero (LUI); alu_src_b  out  1  0 = rs2, 1 = imm.
REQ-014 alu_op  out  2  00 add, 01 branch compare, 10 funct-decoded.
REQ-015 wb_sel  out  2  00 ALU, 01 load data, 10 pc+4, 11 pc+imm.
REQ-016 pc_sel  out  2  00 pc+4, 01 pc+imm, 10 ALU result.
REQ-017 state  out  3; halted, error  out  1; instret  out  32.

Function
REQ-018 States SHALL be IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERR.
REQ-019 IDLE: all strobes 0; start=1 -> FETCH next cycle; start outside IDLE SHALL be ignored.
REQ-020 FETCH: imem_req held 1 until imem_ready; on the imem_ready cycle ir_we=1 and next state DECODE.
REQ-021 DECODE: one cycle; SYSTEM (1110011) -> HALT; unrecognised opcode -> ERR; otherwise -> EXEC.
REQ-022 EXEC: R/I/LUI/AUIPC/JAL/JALR -> WB; load/store -> MEM; branch -> FETCH with pc_we=1, pc_sel=01 if zero=1 else 00.
REQ-023 EXEC controls: alu_src_b=1 except R-type and branch; alu_src_a=1 only for LUI; alu_op=10 for R/I, 01 for branch, else 00.
REQ-024 MEM: dmem_req held 1 (dmem_we=1 for store) until dmem_ready; store -> FETCH with pc_we=1, pc_sel=00; load -> WB.
REQ-025 WB: reg_we=1 and pc_we=1 for exactly one cycle, then FETCH.
REQ-026 WB selects: load wb_sel=01; JAL/JALR wb_sel=10; AUIPC wb_sel=11; else 00; pc_sel=01 JAL, 10 JALR, else 00.
REQ-027 pc_we SHALL assert exactly once per retired instruction; instret increments on that cycle, wrapping 0xFFFFFFFF -> 0.
REQ-028 Wait counter counts cycles in FETCH/MEM with request high and ready low; clears on ready or state change.
REQ-029 Counter reaching WAIT_LIMIT (nonzero) -> ERR next cycle, request dropped; ready arriving on the same cycle wins.
REQ-030 HALT: halted=1, all strobes 0, sticky until reset; ERR: error=1, all strobes 0, sticky until reset.
REQ-031 imem_req/dmem_req SHALL never be high simultaneously; ready inputs outside their request are ignored.
REQ-032 state output SHALL equal the package encoding of the current state.

Reset
REQ-033 rst=0 SHALL asynchronously force IDLE, all outputs 0, instret 0, wait counter 0, including mid-access.
REQ-034 First FETCH after reset SHALL require start=1 sampled high after rst deasserts.

Structure
REQ-035 Shared package rv_ctrl_pkg holds state encoding, opcode constants, alu_op/wb_sel/pc_sel encodings; wb_sel encoding matches datapath writeback mux.
REQ-036 One sub-module, wait_timer (CNT_W counter, clear, enable, limit compare); remainder is one FSM with registered state, combinational outputs.

Verification
REQ-037 ADDI with imem_ready after 2 wait cycles -> FETCH 3 cycles, ir_we once, WB reg_we=1, pc_sel=00, instret 0->1.
REQ-038 BEQ taken (zero=1) -> EXEC pc_we=1, pc_sel=01, no reg_we; not taken (zero=0) -> pc_sel=00.
REQ-039 LW with dmem_ready after 3 cycles -> dmem_req high 4 cycles, dmem_we=0, WB wb_sel=01; SW -> dmem_we=1, no WB.
REQ-040 imem_ready held low, WAIT_LIMIT=16 -> ERR after 16 request cycles, error=1, imem_req=0; ready at count 16 -> DECODE instead.
REQ-041 rst pulsed low during MEM -> dmem_req falls immediately, state=IDLE, instret=0; start ignored while in HALT (ECALL).
REQ-042 JALR -> WB wb_sel=10, pc_sel=10; opcode 0000000 -> ERR from DECODE.
